// File: rtl/mult_pkg.sv
// Shared constants and width helpers for the signed array multiplier family.
package mult_pkg;

    localparam int CSA_BLOCK = 4;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/signed_parallel_multiplier_12_c_sel_a_carry_select_adder.sv
// Two-operand carry-select adder: each block precomputes sums for carry-in 0 and 1,
// and the rippling block carry picks one. Carry out of the MSB is dropped.
module carry_select_adder #(
    parameter int WIDTH = 24,
    parameter int BLOCK = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    localparam int NBLK = (WIDTH + BLOCK - 1) / BLOCK;

    logic [NBLK-1:0] w_c;

    assign w_c[0] = 1'b0;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        localparam int LO  = k * BLOCK;
        localparam int LEN = ((WIDTH - LO) < BLOCK) ? (WIDTH - LO) : BLOCK;

        if (k < NBLK - 1) begin : g_mid
            localparam logic [LEN:0] ONE = 1;
            logic [LEN:0] w_s0;
            logic [LEN:0] w_s1;

            // a+b+1 never exceeds LEN+1 bits, so the cin=1 sum reuses the cin=0 result.
            assign w_s0 = {1'b0, i_a[LO +: LEN]} + {1'b0, i_b[LO +: LEN]};
            assign w_s1 = w_s0 + ONE;
            assign o_sum[LO +: LEN] = w_c[k] ? w_s1[LEN-1:0] : w_s0[LEN-1:0];
            assign w_c[k+1]         = w_c[k] ? w_s1[LEN]     : w_s0[LEN];
        end else begin : g_last
            localparam logic [LEN-1:0] ONE = 1;
            logic [LEN-1:0] w_s0;
            logic [LEN-1:0] w_s1;

            assign w_s0 = i_a[LO +: LEN] + i_b[LO +: LEN];
            assign w_s1 = w_s0 + ONE;
            assign o_sum[LO +: LEN] = w_c[k] ? w_s1 : w_s0;
        end
    end

endmodule

// File: rtl/signed_parallel_multiplier_12_c_sel_a.sv
// Signed Baugh-Wooley array multiplier: carry-save reduction of the partial-product
// rows to two rows, final carry-select addition, plus a registered product copy.
module signed_parallel_multiplier_12_c_sel_a
    import mult_pkg::*;
#(
    parameter int width = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [width:1]               A,
    input  logic [width:1]               B,
    output logic [prod_width(width):1]   S,
    output logic [prod_width(width):1]   S_q
);

    localparam int W = width;
    localparam int P = prod_width(width);

    localparam logic [P-1:0] ONE_P    = 1;
    // Baugh-Wooley correction: +2^W and +2^(2W-1) undo the inverted sign rows.
    localparam logic [P-1:0] BW_CONST = (ONE_P << W) | (ONE_P << (P - 1));

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [P-1:0] w_row [W];
    logic [P-1:0] w_sum [W+1];
    logic [P-1:0] w_car [W+1];
    logic [P-1:0] w_prod;
    logic [P-1:0] r_s_q;

    assign w_a = A;
    assign w_b = B;

    for (genvar i = 0; i < W; i++) begin : g_pp
        localparam logic [W-1:0] INV = (i == W - 1) ? {1'b0, {(W-1){1'b1}}}
                                                    : {1'b1, {(W-1){1'b0}}};
        logic [W-1:0] w_bits;

        assign w_bits   = ({W{w_a[i]}} & w_b) ^ INV;
        assign w_row[i] = {{W{1'b0}}, w_bits} << i;
    end

    assign w_sum[0] = BW_CONST;
    assign w_car[0] = '0;

    // One full-adder row per partial product keeps the array in sum/carry form.
    for (genvar r = 0; r < W; r++) begin : g_red
        logic [P-2:0] w_maj;

        assign w_maj = (w_sum[r][P-2:0] & w_car[r][P-2:0])
                     | (w_sum[r][P-2:0] & w_row[r][P-2:0])
                     | (w_car[r][P-2:0] & w_row[r][P-2:0]);
        assign w_sum[r+1] = w_sum[r] ^ w_car[r] ^ w_row[r];
        assign w_car[r+1] = {w_maj, 1'b0};
    end

    carry_select_adder #(
        .WIDTH (P),
        .BLOCK (CSA_BLOCK)
    ) u_csa (
        .i_a   (w_sum[W]),
        .i_b   (w_car[W]),
        .o_sum (w_prod)
    );

    assign S = w_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q <= '0;
        end else begin
            r_s_q <= w_prod;
        end
    end

    assign S_q = r_s_q;

endmodule

// File: tb/tb_signed_parallel_multiplier_12_c_sel_a.sv
// Scoreboard bench for the 12-bit signed multiplier: combinational and registered product.
module tb_signed_parallel_multiplier_12_c_sel_a;

    localparam int W = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W:1]      A;
    logic [W:1]      B;
    logic [2*W:1]    S;
    logic [2*W:1]    S_q;

    always #5 clk = ~clk;

    signed_parallel_multiplier_12_c_sel_a #(
        .width (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .S     (S),
        .S_q   (S_q)
    );

    logic [23:0] q_exp [$];
    bit          q_isq [$];
    string       q_nm  [$];
    logic        strobe = 1'b0;
    int          n_vec  = 0;
    int          n_err  = 0;

    task automatic push(input logic [23:0] e, input bit isq, input string nm);
        q_exp.push_back(e);
        q_isq.push_back(isq);
        q_nm.push_back(nm);
    endtask

    task automatic pulse();
        strobe = 1'b1;
        #1;
        strobe = 1'b0;
    endtask

    task automatic apply(input int a, input int b, input logic [23:0] e, input string nm);
        A = a[W-1:0];
        B = b[W-1:0];
        push(e, 1'b0, nm);
        #10;
        pulse();
    endtask

    // Monitor: drains every queued expectation at each sample strobe.
    initial begin
        forever begin
            @(posedge strobe);
            while (q_exp.size() > 0) begin
                logic [23:0] e;
                logic [23:0] act;
                bit          isq;
                string       nm;
                e   = q_exp.pop_front();
                isq = q_isq.pop_front();
                nm  = q_nm.pop_front();
                act = isq ? S_q : S;
                n_vec++;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h", nm, act, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0]        ra;
        logic [31:0]        rb;
        logic signed [11:0] sa;
        logic signed [11:0] sb;
        logic signed [23:0] p;

        rst_n = 1'b0;
        A     = '0;
        B     = '0;
        #1;
        push(24'h000000, 1'b1, "sq_reset_no_edge");
        pulse();

        apply(3,     5,     24'h00000F, "3x5");
        apply(-1,    -1,    24'h000001, "m1xm1");
        apply(-2048, -2048, 24'h400000, "minxmin");
        apply(-2048, 2047,  24'hC00800, "minxmax");
        apply(2047,  2047,  24'h3FF001, "maxxmax");
        apply(0,     -1234, 24'h000000, "0xm1234");
        apply(1,     -7,    24'hFFFFF9, "1xm7");
        apply(-1,    1,     24'hFFFFFF, "m1x1");
        apply(-2048, 1,     24'hFFF800, "minx1");
        apply(100,   -100,  24'hFFD8F0, "100xm100");

        push(24'h000000, 1'b1, "sq_held_in_reset");
        pulse();

        for (int k = 0; k < 60; k++) begin
            ra = $urandom;
            rb = $urandom;
            sa = ra[11:0];
            sb = rb[11:0];
            p  = sa * sb;
            apply(int'(ra), int'(rb), p, "random");
        end

        @(negedge clk);
        rst_n = 1'b1;
        A     = 12'hFFD;
        B     = 12'h004;
        @(posedge clk);
        #1;
        push(24'hFFFFF4, 1'b1, "sq_m3x4");
        push(24'hFFFFF4, 1'b0, "s_m3x4");
        pulse();

        @(negedge clk);
        A = 12'h7FF;
        B = 12'h7FF;
        @(posedge clk);
        #1;
        push(24'h3FF001, 1'b1, "sq_maxxmax");
        pulse();

        @(negedge clk);
        A = 12'hFFD;
        B = 12'h004;
        @(posedge clk);
        #1;
        push(24'hFFFFF4, 1'b1, "sq_m3x4_again");
        pulse();
        #1;
        rst_n = 1'b0;
        #1;
        push(24'h000000, 1'b1, "sq_async_reset");
        push(24'hFFFFF4, 1'b0, "s_during_reset");
        pulse();

        #5;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
